// File: rtl/decode_stage_pipelined.sv
// Instruction-decode stage: IF/ID and ID/EX pipeline registers, register file,
// main decoder, early BEQ/BNE resolution with operand forwarding, and jump target.
module decode_stage_pipelined #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int REG_COUNT  = 32,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           InstrF,
    input  logic [31:0]           PCPlus4F,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  FlushE,
    input  logic [1:0]            ForwardAD,
    input  logic [1:0]            ForwardBD,
    input  logic [DATA_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic [REG_ADDR-1:0]   WriteRegW,
    input  logic                  RegWriteW,
    output logic [1:0]            PCSrcD,
    output logic [31:0]           PCBranchD,
    output logic [31:0]           PCJumpD,
    output logic [REG_ADDR-1:0]   RsD,
    output logic [REG_ADDR-1:0]   RtD,
    output logic                  BranchD,
    output logic                  JumpD,
    output logic                  MemtoRegD,
    output logic                  RegWriteD,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] SignImmE,
    output logic [REG_ADDR-1:0]   RsE,
    output logic [REG_ADDR-1:0]   RtE,
    output logic [REG_ADDR-1:0]   RdE,
    output logic                  ValidE
);

    localparam int RF_DEPTH = 1 << REG_ADDR;

    logic [31:0]           instr_d_r;
    logic [31:0]           pc_plus4_d_r;
    logic [DATA_WIDTH-1:0] rf_r [0:RF_DEPTH-1];

    logic [5:0]            opcode_s;
    logic [5:0]            funct_s;
    logic [REG_ADDR-1:0]   rd_d_s;
    logic                  mem_write_s;
    logic                  alu_src_s;
    logic                  reg_dst_s;
    logic                  branch_ne_s;
    logic [ALU_CTRL_W-1:0] alu_ctrl_s;
    logic [DATA_WIDTH-1:0] sign_imm_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;
    logic [DATA_WIDTH-1:0] cmp_a_s;
    logic [DATA_WIDTH-1:0] cmp_b_s;
    logic                  taken_s;
    logic                  rf_we_s;

    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        case (funct)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Unmapped addresses and r0 read as zero; a same-cycle write is bypassed.
    function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [REG_ADDR-1:0] addr);
        if ((addr == {REG_ADDR{1'b0}}) || (int'(addr) >= REG_COUNT)) begin
            return {DATA_WIDTH{1'b0}};
        end else if (RegWriteW && (WriteRegW == addr)) begin
            return ResultW;
        end else begin
            return rf_r[addr];
        end
    endfunction

    assign opcode_s   = instr_d_r[31:26];
    assign funct_s    = instr_d_r[5:0];
    assign RsD        = REG_ADDR'(instr_d_r[25:21]);
    assign RtD        = REG_ADDR'(instr_d_r[20:16]);
    assign rd_d_s     = REG_ADDR'(instr_d_r[15:11]);
    assign sign_imm_s = {{(DATA_WIDTH-16){instr_d_r[15]}}, instr_d_r[15:0]};
    assign rf_we_s    = RegWriteW && (WriteRegW != {REG_ADDR{1'b0}}) && (int'(WriteRegW) < REG_COUNT);

    // IF/ID pipeline register: flush wins over stall.
    always_ff @(posedge CLK) begin
        if (RST || FlushD) begin
            instr_d_r    <= 32'd0;
            pc_plus4_d_r <= 32'd0;
        end else if (!StallD) begin
            instr_d_r    <= InstrF;
            pc_plus4_d_r <= PCPlus4F;
        end
    end

    // Register file storage; entries beyond REG_COUNT are never written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (rf_we_s) begin
            rf_r[WriteRegW] <= ResultW;
        end
    end

    // Main decoder; unknown opcodes decode to an all-zero control word.
    always_comb begin
        RegWriteD   = 1'b0;
        MemtoRegD   = 1'b0;
        mem_write_s = 1'b0;
        alu_src_s   = 1'b0;
        reg_dst_s   = 1'b0;
        BranchD     = 1'b0;
        branch_ne_s = 1'b0;
        JumpD       = 1'b0;
        alu_ctrl_s  = {ALU_CTRL_W{1'b0}};
        case (opcode_s)
            6'b000000: begin
                RegWriteD  = 1'b1;
                reg_dst_s  = 1'b1;
                alu_ctrl_s = ALU_CTRL_W'(funct_alu(funct_s));
            end
            6'b100011: begin
                RegWriteD  = 1'b1;
                alu_src_s  = 1'b1;
                MemtoRegD  = 1'b1;
                alu_ctrl_s = ALU_CTRL_W'(3'b010);
            end
            6'b101011: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                alu_ctrl_s  = ALU_CTRL_W'(3'b010);
            end
            6'b000100: begin
                BranchD    = 1'b1;
                alu_ctrl_s = ALU_CTRL_W'(3'b110);
            end
            6'b000101: begin
                BranchD     = 1'b1;
                branch_ne_s = 1'b1;
                alu_ctrl_s  = ALU_CTRL_W'(3'b110);
            end
            6'b001000: begin
                RegWriteD  = 1'b1;
                alu_src_s  = 1'b1;
                alu_ctrl_s = ALU_CTRL_W'(3'b010);
            end
            6'b000010: begin
                JumpD = 1'b1;
            end
            default: begin
                RegWriteD = 1'b0;
            end
        endcase
    end

    // Operand read plus branch-compare forwarding (encoding 11 falls back to the RF).
    always_comb begin
        rd1_s = rf_read(RsD);
        rd2_s = rf_read(RtD);
        case (ForwardAD)
            2'b01:   cmp_a_s = ALUOutM;
            2'b10:   cmp_a_s = ResultW;
            default: cmp_a_s = rd1_s;
        endcase
        case (ForwardBD)
            2'b01:   cmp_b_s = ALUOutM;
            2'b10:   cmp_b_s = ResultW;
            default: cmp_b_s = rd2_s;
        endcase
    end

    assign taken_s   = BranchD && (branch_ne_s ? (cmp_a_s != cmp_b_s) : (cmp_a_s == cmp_b_s));
    assign PCSrcD    = {JumpD, taken_s};
    assign PCBranchD = pc_plus4_d_r + {sign_imm_s[29:0], 2'b00};
    assign PCJumpD   = {pc_plus4_d_r[31:28], instr_d_r[25:0], 2'b00};

    // ID/EX pipeline register: no stall, flush inserts a bubble.
    always_ff @(posedge CLK) begin
        if (RST || FlushE) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= {ALU_CTRL_W{1'b0}};
            RD1E        <= {DATA_WIDTH{1'b0}};
            RD2E        <= {DATA_WIDTH{1'b0}};
            SignImmE    <= {DATA_WIDTH{1'b0}};
            RsE         <= {REG_ADDR{1'b0}};
            RtE         <= {REG_ADDR{1'b0}};
            RdE         <= {REG_ADDR{1'b0}};
            ValidE      <= 1'b0;
        end else begin
            RegWriteE   <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= mem_write_s;
            ALUSrcE     <= alu_src_s;
            RegDstE     <= reg_dst_s;
            ALUControlE <= alu_ctrl_s;
            RD1E        <= rd1_s;
            RD2E        <= rd2_s;
            SignImmE    <= sign_imm_s;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= rd_d_s;
            ValidE      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed self-checking bench for decode_stage_pipelined (REG_COUNT=16 to
// exercise out-of-range register addresses).
module tb_decode_stage_pipelined;

    logic        CLK;
    logic        RST;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAD;
    logic [1:0]  ForwardBD;
    logic [31:0] ALUOutM;
    logic [31:0] ResultW;
    logic [4:0]  WriteRegW;
    logic        RegWriteW;
    logic [1:0]  PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] PCJumpD;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic        BranchD;
    logic        JumpD;
    logic        MemtoRegD;
    logic        RegWriteD;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic        ALUSrcE;
    logic        RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] SignImmE;
    logic [4:0]  RsE;
    logic [4:0]  RtE;
    logic [4:0]  RdE;
    logic        ValidE;

    int checks_cnt;
    int errors_cnt;

    decode_stage_pipelined #(
        .DATA_WIDTH(32), .REG_ADDR(5), .REG_COUNT(16), .ALU_CTRL_W(3)
    ) dut (
        .CLK(CLK), .RST(RST), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ALUOutM(ALUOutM), .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpD(JumpD),
        .MemtoRegD(MemtoRegD), .RegWriteD(RegWriteD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .ValidE(ValidE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        RST = 1'b1; InstrF = 32'd0; PCPlus4F = 32'd0;
        StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        ForwardAD = 2'b00; ForwardBD = 2'b00;
        ALUOutM = 32'd0; ResultW = 32'd0; WriteRegW = 5'd0; RegWriteW = 1'b0;

        // Reset state
        tick();
        check_eq("rst_validE", 32'(ValidE), 32'd0);
        check_eq("rst_regwriteE", 32'(RegWriteE), 32'd0);
        check_eq("rst_rd1E", RD1E, 32'd0);
        check_eq("rst_signimmE", SignImmE, 32'd0);
        check_eq("rst_pcsrc", 32'(PCSrcD), 32'd0);
        RST = 1'b0;

        // Preload r1=7, r2=3
        RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'd7;
        tick();
        WriteRegW = 5'd2; ResultW = 32'd3;
        tick();
        RegWriteW = 1'b0; ResultW = 32'd0;

        // Write-through bypass of r5 while decoding add r7,r5,r0
        InstrF = r_type(5'd5, 5'd0, 5'd7, 6'h20); PCPlus4F = 32'h4;
        tick();
        RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'hDEAD_BEEF;
        tick();
        check_eq("bypass_rd1E", RD1E, 32'hDEAD_BEEF);
        check_eq("add_rsE", 32'(RsE), 32'd5);
        check_eq("add_rdE", 32'(RdE), 32'd7);
        check_eq("add_ctrl", {27'd0, RegWriteE, RegDstE, ALUControlE}, {27'd0, 1'b1, 1'b1, 3'b010});
        check_eq("add_validE", 32'(ValidE), 32'd1);
        RegWriteW = 1'b0; ResultW = 32'd0;
        tick();
        check_eq("rf_r5_stored", RD1E, 32'hDEAD_BEEF);

        // beq r1,r2 with r2 forwarded from MEM
        InstrF = i_type(6'b000100, 5'd1, 5'd2, 16'd4); PCPlus4F = 32'h0000_1004;
        tick();
        ForwardBD = 2'b01; ALUOutM = 32'd7;
        #1;
        check_eq("beq_fwd_pcsrc", 32'(PCSrcD), 32'd1);
        check_eq("beq_pcbranch", PCBranchD, 32'h0000_1014);
        check_eq("beq_fields", {22'd0, BranchD, RsD, RtD}, {22'd0, 1'b1, 5'd1, 5'd2});
        ForwardBD = 2'b00;
        #1;
        check_eq("beq_rf_pcsrc", 32'(PCSrcD), 32'd0);
        ForwardBD = 2'b11;
        #1;
        check_eq("beq_fwd11_pcsrc", 32'(PCSrcD), 32'd0);

        // bne with negative offset
        InstrF = i_type(6'b000101, 5'd1, 5'd2, 16'hFFFE); PCPlus4F = 32'h0000_2000;
        ForwardBD = 2'b01;
        tick();
        check_eq("beq_aluE", 32'(ALUControlE), 32'd6);
        check_eq("beq_signimmE", SignImmE, 32'd4);
        check_eq("bne_fwd_pcsrc", 32'(PCSrcD), 32'd0);
        check_eq("bne_pcbranch", PCBranchD, 32'h0000_1FF8);
        ForwardBD = 2'b00;
        #1;
        check_eq("bne_rf_pcsrc", 32'(PCSrcD), 32'd1);
        ForwardAD = 2'b10; ResultW = 32'd3;
        #1;
        check_eq("bne_fwdA_pcsrc", 32'(PCSrcD), 32'd0);
        ForwardAD = 2'b00; ResultW = 32'd0;

        // Jump target
        InstrF = {6'b000010, 26'h000_0100}; PCPlus4F = 32'h4000_0008;
        tick();
        check_eq("bne_signimmE", SignImmE, 32'hFFFF_FFFE);
        check_eq("j_pcsrc", 32'(PCSrcD), 32'd2);
        check_eq("j_pcjump", PCJumpD, 32'h4000_0400);
        check_eq("j_jumpD", 32'(JumpD), 32'd1);

        // lw / sw control words
        InstrF = i_type(6'b100011, 5'd1, 5'd8, 16'h0010);
        tick();
        check_eq("lw_memtoregD", 32'(MemtoRegD), 32'd1);
        tick();
        check_eq("lw_ctrlE", {26'd0, MemtoRegE, ALUSrcE, RegWriteE, RegDstE, MemWriteE, ValidE},
                 {26'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        check_eq("lw_rtE", 32'(RtE), 32'd8);
        InstrF = i_type(6'b101011, 5'd1, 5'd8, 16'h0010);
        tick();
        tick();
        check_eq("sw_ctrlE", {27'd0, MemWriteE, ALUSrcE, RegWriteE, MemtoRegE, RegDstE},
                 {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

        // Stall, FlushE during stall, then FlushD with StallD
        InstrF = r_type(5'd3, 5'd4, 5'd9, 6'h22);
        tick();
        check_eq("stall_pre_rsD", 32'(RsD), 32'd3);
        StallD = 1'b1; InstrF = r_type(5'd10, 5'd11, 5'd12, 6'h20);
        tick();
        check_eq("stall1_rsD", 32'(RsD), 32'd3);
        FlushE = 1'b1;
        tick();
        check_eq("stall2_rsD", 32'(RsD), 32'd3);
        check_eq("flushE_validE", 32'(ValidE), 32'd0);
        FlushE = 1'b0;
        tick();
        check_eq("stall3_rtD", 32'(RtD), 32'd4);
        check_eq("postflush_validE", 32'(ValidE), 32'd1);
        check_eq("sub_aluE", 32'(ALUControlE), 32'd6);
        FlushD = 1'b1;
        tick();
        check_eq("flushD_rs_rt", {22'd0, RsD, RtD}, 32'd0);
        check_eq("flushD_pcjump", PCJumpD, 32'd0);
        StallD = 1'b0; FlushD = 1'b0;

        // r0 is never written, even via bypass
        RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'h0000_1234;
        InstrF = r_type(5'd0, 5'd0, 5'd1, 6'h20);
        tick();
        tick();
        check_eq("r0_rd1E", RD1E, 32'd0);
        RegWriteW = 1'b0; ResultW = 32'd0;

        // Unknown opcode decodes to NOP but stays valid
        InstrF = {6'h3F, 5'd1, 5'd2, 16'h8000};
        tick();
        check_eq("unk_ctrlD", {28'd0, RegWriteD, MemtoRegD, BranchD, JumpD}, 32'd0);
        check_eq("unk_pcsrc", 32'(PCSrcD), 32'd0);
        tick();
        check_eq("unk_ctrlE", {24'd0, RegWriteE, MemWriteE, ALUSrcE, RegDstE, MemtoRegE, ALUControlE},
                 32'd0);
        check_eq("unk_validE", 32'(ValidE), 32'd1);
        check_eq("unk_signimmE", SignImmE, 32'hFFFF_8000);
        check_eq("unk_rd_pair", {RD1E[15:0], RD2E[15:0]}, {16'd7, 16'd3});

        // Out-of-range r20 neither written nor bypassed; r15 is the last real register
        RegWriteW = 1'b1; WriteRegW = 5'd20; ResultW = 32'hAAAA_5555;
        InstrF = r_type(5'd20, 5'd1, 5'd3, 6'h20);
        tick();
        tick();
        check_eq("r20_bypass_rd1E", RD1E, 32'd0);
        check_eq("r20_rd2E", RD2E, 32'd7);
        RegWriteW = 1'b0;
        tick();
        check_eq("r20_rd1E", RD1E, 32'd0);
        RegWriteW = 1'b1; WriteRegW = 5'd15; ResultW = 32'h5A5A_5A5A;
        InstrF = r_type(5'd15, 5'd0, 5'd3, 6'h20);
        tick();
        RegWriteW = 1'b0; ResultW = 32'd0;
        tick();
        check_eq("r15_rd1E", RD1E, 32'h5A5A_5A5A);

        // Mid-stream reset clears pipeline and register file
        InstrF = r_type(5'd1, 5'd2, 5'd3, 6'h20);
        tick();
        RST = 1'b1;
        tick();
        check_eq("mrst_validE", 32'(ValidE), 32'd0);
        check_eq("mrst_rsD_rsE", {22'd0, RsD, RsE}, 32'd0);
        RST = 1'b0;
        tick();
        tick();
        check_eq("mrst_rf_r1", RD1E, 32'd0);
        check_eq("mrst_validE_after", 32'(ValidE), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
